// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
// Cache-side request/response bus between the data-cache controller and the
// SRAM responder.
//   req    level request, held by the requester until ack is seen
//   we     1 = write (store-through), 0 = read (line fill); valid with req
//   addr   16-bit word address; valid with req
//   wdata  store data; valid with req when we = 1
//   rdata  read data; valid in the ack cycle, holds until the next read ends
//   ack    one-cycle completion pulse
//   busy   responder is not idle
// Modports: master = cache controller, slave = responder.
// ---------------------------------------------------------------------------
interface sram_responder_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
  );
endinterface : sram_responder_if

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Memory-side responder for the 16-bit MIPS data cache. Accepts single-word
// reads and writes over a req/ack handshake and sequences the asynchronous
// off-chip SRAM control pins with configurable wait states.
//
// Parameters
//   READ_WAIT   cycles CE/OE are held low before dq is sampled (1..15)
//   WRITE_WAIT  cycles WE is held low (1..15)
// Ports
//   clk          system clock, all state on the rising edge
//   rst          synchronous, active-high reset
//   bus          cache-side request/response bus (slave side)
//   sram_addr    {2'b00, latched word address}
//   sram_dq_out  latched store data, driven to the pads when sram_dq_oe = 1
//   sram_dq_oe   1 = pad wrapper drives dq
//   sram_dq_in   pad input data
//   sram_ce_n, sram_oe_n, sram_we_n   active-low SRAM strobes
//   sram_ub_n, sram_lb_n              byte lanes, always enabled
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_responder_if.slave        bus,
  output logic [17:0]            sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } state_t;

  // The counter is loaded with WAIT-1 so the strobe phase lasts exactly WAIT
  // cycles, ending on the cycle where the counter reads zero.
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        accept;   // IDLE with req: latch the request fields
  logic        capture;  // last RD cycle: register the pad data
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (capture) begin
        rdata_q <= sram_dq_in;
      end
    end
  end

  // Next-state logic and Moore-decoded outputs.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    bus.ack    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (bus.we) begin
            state_next = WR_SETUP;
          end else begin
            state_next = RD;
            cnt_next   = RD_LOAD;
          end
        end
      end

      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = ACK;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      // Data is driven one cycle ahead of the WE pulse for address/data setup.
      WR_SETUP: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        cnt_next   = WR_LOAD;
        state_next = WR_PULSE;
      end

      WR_PULSE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        if (cnt == 4'd0) begin
          state_next = WR_HOLD;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      // Data held one cycle past the rising WE edge for hold time.
      WR_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
        state_next = ACK;
      end

      // Pads released here, so a write followed by a read never contends.
      ACK: begin
        bus.ack    = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.rdata   = rdata_q;
  assign sram_addr   = {2'b00, addr_q};
  assign sram_dq_out = wdata_q;
  assign sram_ub_n   = 1'b0;
  assign sram_lb_n   = 1'b0;

endmodule : sram_responder

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
// Directed bench for sram_responder. Two instances: dut_a with default wait
// states (READ_WAIT=2, WRITE_WAIT=1) and dut_b with READ_WAIT=4, WRITE_WAIT=3.
// Stimulus pushes the expected ack cycle and rdata into a per-DUT queue; a
// monitor pops and compares on every ack. Pin waveforms are compared cycle by
// cycle against the timing table of the responder.
// ---------------------------------------------------------------------------
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          contention = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_responder_if if_a ();
  sram_responder_if if_b ();

  logic [17:0] sram_addr_a, sram_addr_b;
  logic [15:0] dq_out_a, dq_out_b, dq_in_a, dq_in_b;
  logic        dq_oe_a, dq_oe_b;
  logic        ce_n_a, oe_n_a, we_n_a, ub_n_a, lb_n_a;
  logic        ce_n_b, oe_n_b, we_n_b, ub_n_b, lb_n_b;

  sram_responder dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (if_a),
    .sram_addr  (sram_addr_a),
    .sram_dq_out(dq_out_a),
    .sram_dq_oe (dq_oe_a),
    .sram_dq_in (dq_in_a),
    .sram_ce_n  (ce_n_a),
    .sram_oe_n  (oe_n_a),
    .sram_we_n  (we_n_a),
    .sram_ub_n  (ub_n_a),
    .sram_lb_n  (lb_n_a)
  );

  sram_responder #(.READ_WAIT(4), .WRITE_WAIT(3)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (if_b),
    .sram_addr  (sram_addr_b),
    .sram_dq_out(dq_out_b),
    .sram_dq_oe (dq_oe_b),
    .sram_dq_in (dq_in_b),
    .sram_ce_n  (ce_n_b),
    .sram_oe_n  (oe_n_b),
    .sram_we_n  (we_n_b),
    .sram_ub_n  (ub_n_b),
    .sram_lb_n  (lb_n_b)
  );

  // {busy, ce_n, oe_n, we_n, dq_oe}
  logic [4:0] pins_a, pins_b;
  assign pins_a = {if_a.busy, ce_n_a, oe_n_a, we_n_a, dq_oe_a};
  assign pins_b = {if_b.busy, ce_n_b, oe_n_b, we_n_b, dq_oe_b};

  localparam logic [4:0] PINS_IDLE = 5'b0_111_0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b;
  logic [15:0] model_rdata [2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pins at cycle offset k of a transaction (k = 0 is the accept cycle).
  function automatic logic [4:0] exp_pins(logic w, int k, int rw, int ww);
    if (!w) begin
      if (k >= 1 && k <= rw)    return 5'b1_001_0;
      if (k == rw + 1)          return 5'b1_111_0;
      return PINS_IDLE;
    end
    if (k == 1)                 return 5'b1_011_1;
    if (k >= 2 && k <= ww + 1)  return 5'b1_010_1;
    if (k == ww + 2)            return 5'b1_011_1;
    if (k == ww + 3)            return 5'b1_111_0;
    return PINS_IDLE;
  endfunction

  task automatic drive(int sel, logic r, logic w, logic [15:0] a, logic [15:0] d);
    if (sel == 0) begin
      if_a.req = r; if_a.we = w; if_a.addr = a; if_a.wdata = d;
    end else begin
      if_b.req = r; if_b.we = w; if_b.addr = a; if_b.wdata = d;
    end
  endtask

  task automatic set_dq(int sel, logic [15:0] v);
    if (sel == 0) dq_in_a = v;
    else          dq_in_b = v;
  endtask

  // Runs one transaction starting at the current negedge (an IDLE cycle).
  // With hold=1 req stays high through the ack cycle for a back-to-back issue.
  task automatic txn(int sel, logic w, logic [15:0] a, logic [15:0] d,
                     logic [15:0] dqv, bit hold);
    int   rw  = (sel == 0) ? 2 : 4;
    int   ww  = (sel == 0) ? 1 : 3;
    int   lat = w ? ww + 3 : rw + 1;
    exp_t e;
    string tag;
    tag = $sformatf("%s %s 0x%04h", (sel == 0) ? "A" : "B", w ? "wr" : "rd", a);
    drive(sel, 1'b1, w, a, d);
    set_dq(sel, ~dqv);
    if (!w) model_rdata[sel] = dqv;
    e.cyc   = cyc + lat;
    e.rdata = model_rdata[sel];
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      check($sformatf("%s pins k=%0d", tag, k),
            32'((sel == 0) ? pins_a : pins_b), 32'(exp_pins(w, k, rw, ww)));
      if (k == 1) begin
        check({tag, " sram_addr"}, 32'((sel == 0) ? sram_addr_a : sram_addr_b),
              32'({2'b00, a}));
        if (w) check({tag, " dq_out"}, 32'((sel == 0) ? dq_out_a : dq_out_b), 32'(d));
      end
      // Correct data appears only during the last RD cycle.
      if (!w && k == rw)     set_dq(sel, dqv);
      if (!w && k == rw + 1) set_dq(sel, ~dqv);
      if (k == lat && !hold) drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
    end
  endtask

  // Scoreboard monitors: every ack must match the head of the queue.
  always @(negedge clk) begin
    if (if_a.ack === 1'b1) begin
      if (q_a.size() == 0) begin
        check("A unexpected ack", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("A ack cycle", cyc, e_a.cyc);
        check("A rdata", 32'(if_a.rdata), 32'(e_a.rdata));
      end
    end
    if (if_b.ack === 1'b1) begin
      if (q_b.size() == 0) begin
        check("B unexpected ack", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("B ack cycle", cyc, e_b.cyc);
        check("B rdata", 32'(if_b.rdata), 32'(e_b.rdata));
      end
    end
    if (dq_oe_a && !oe_n_a) contention++;
    if (dq_oe_b && !oe_n_b) contention++;
  end

  initial begin
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    dq_in_a = 16'h0;
    dq_in_b = 16'h0;

    // Reset held two cycles with req asserted.
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h1111, 16'h2222);
    drive(1, 1'b1, 1'b1, 16'h3333, 16'h4444);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("A reset pins", 32'(pins_a), 32'(PINS_IDLE));
    check("B reset pins", 32'(pins_b), 32'(PINS_IDLE));
    check("A reset ack", 32'(if_a.ack), 32'd0);
    check("A reset rdata", 32'(if_a.rdata), 32'd0);
    check("A reset sram_addr", 32'(sram_addr_a), 32'd0);
    check("A reset dq_out", 32'(dq_out_a), 32'd0);
    check("A ub/lb", 32'({ub_n_a, lb_n_a}), 32'd0);
    check("B reset rdata", 32'(if_b.rdata), 32'd0);
    check("B reset sram_addr", 32'(sram_addr_b), 32'd0);
    check("B ub/lb", 32'({ub_n_b, lb_n_b}), 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    // Default wait states: single read, then single write.
    txn(0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 1'b0);
    txn(0, 1'b1, 16'h00A5, 16'h5A5A, 16'h0000, 1'b0);

    // Back-to-back: req held through the first ack.
    txn(0, 1'b0, 16'h0010, 16'h0000, 16'h1357, 1'b1);
    txn(0, 1'b1, 16'h0011, 16'h2468, 16'h0000, 1'b0);
    check("A rdata after write", 32'(if_a.rdata), 32'h1357);

    // Reset during the WE pulse: aborted without an ack.
    drive(0, 1'b1, 1'b1, 16'h0033, 16'hAAAA);
    @(negedge clk);
    check("A abort setup pins", 32'(pins_a), 32'b1_011_1);
    @(negedge clk);
    check("A abort pulse pins", 32'(pins_a), 32'b1_010_1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("A abort pins after rst", 32'(pins_a), 32'(PINS_IDLE));
    check("A abort sram_addr", 32'(sram_addr_a), 32'd0);
    check("A abort rdata", 32'(if_a.rdata), 32'd0);
    rst = 1'b0;
    model_rdata[0] = 16'h0;
    model_rdata[1] = 16'h0;
    repeat (6) begin
      @(negedge clk);
      check("A idle after abort", 32'(pins_a), 32'(PINS_IDLE));
    end

    // Long wait states on dut_b.
    txn(1, 1'b0, 16'h0F0F, 16'h0000, 16'hC3C3, 1'b0);
    txn(1, 1'b1, 16'h0101, 16'h7E7E, 16'h0000, 1'b0);
    check("B rdata after write", 32'(if_b.rdata), 32'hC3C3);

    repeat (5) @(negedge clk);
    check("A acks outstanding", q_a.size(), 32'd0);
    check("B acks outstanding", q_b.size(), 32'd0);
    check("dq_oe with oe_n low", contention, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sram_responder
